// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry, output-buffer state type and
// wrap-aware pointer subtraction used by both the read and write sides.
package fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2
  } buf_state_e;

  // Pointers are ADDR_W+1 bits wide; callers zero-extend into 32 bits and
  // truncate the result back to ADDR_W+1 bits.
  function automatic logic [31:0] ptr_diff(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int          addr_w);
    logic [31:0] mask;
    mask = (32'd1 << (addr_w + 1)) - 32'd1;
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry skid buffer between the RAM read port and the downstream
// valid/ready stream; reports its occupancy so the reader can budget credit.
//
//   state | meaning
//   B0    | empty, m_valid low
//   B1    | head holds one word
//   B2    | head and tail both hold words
module fifo_out_buf
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_valid_o,
  output logic [1:0]        occupancy_o
);

  buf_state_e        state_q;
  logic [DATA_W-1:0] head_q;
  logic [DATA_W-1:0] tail_q;
  logic              valid_q;
  logic              pop;

  assign pop = valid_q && m_ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= B0;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        B0: begin
          if (wr_en_i) begin
            head_q  <= wr_data_i;
            state_q <= B1;
            valid_q <= 1'b1;
          end
        end
        B1: begin
          case ({wr_en_i, pop})
            2'b10: begin
              tail_q  <= wr_data_i;
              state_q <= B2;
            end
            2'b01: begin
              state_q <= B0;
              valid_q <= 1'b0;
            end
            2'b11: head_q <= wr_data_i;
            default: ;
          endcase
        end
        B2: begin
          // Credit forbids a capture here unless the head drains in the same cycle.
          if (pop) begin
            head_q <= tail_q;
            if (wr_en_i) begin
              tail_q <= wr_data_i;
            end else begin
              state_q <= B1;
            end
          end
        end
        default: begin
          state_q <= B0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    occupancy_o = 2'd0;
    case (state_q)
      B1:      occupancy_o = 2'd1;
      B2:      occupancy_o = 2'd2;
      default: occupancy_o = 2'd0;
    endcase
  end

  assign m_data_o  = head_q;
  assign m_valid_o = valid_q;

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side FIFO controller: owns the read pointer, issues RAM reads under a
// two-word credit and streams words out. FIFO_RD_OVF_CHK_EN adds ovf_err.
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W:0]   w_ptr,
  output logic [ADDR_W-1:0] r_ptr,
  output logic              r_en,
  output logic              empty_flag,
  input  logic [DATA_W-1:0] ram_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W:0]   level
`ifdef FIFO_RD_OVF_CHK_EN
  ,
  output logic              ovf_err
`endif
);

  localparam int PW = ADDR_W + 1;

  logic [ADDR_W:0] rd_ptr_q;
  logic [ADDR_W:0] rd_ptr_d;
  logic            inflight_q;
  logic [1:0]      occupancy;
  logic [1:0]      credit_used;

  assign empty_flag  = (w_ptr == rd_ptr_q);
  assign level       = PW'(ptr_diff(32'(w_ptr), 32'(rd_ptr_q), ADDR_W));
  assign credit_used = occupancy + {1'b0, inflight_q};
  assign r_en        = !empty_flag && (credit_used < 2'd2);
  assign r_ptr       = rd_ptr_q[ADDR_W-1:0];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (r_en) begin
      rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, 1'b1};
    end
  end

  // Clearing inflight on reset drops any RAM word still returning.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= r_en;
    end
  end

  fifo_out_buf #(
    .DATA_W (DATA_W)
  ) u_out_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en_i     (inflight_q),
    .wr_data_i   (ram_data),
    .m_ready_i   (m_ready),
    .m_data_o    (m_data),
    .m_valid_o   (m_valid),
    .occupancy_o (occupancy)
  );

`ifdef FIFO_RD_OVF_CHK_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (level > PW'(1 << ADDR_W)) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_err = ovf_q;
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: vector table, directed reset sequences and a
// randomized stream checked against a word-count scoreboard.
module tb_fifo_read_ctrl;

  logic       clk;
  logic       rst_n;
  logic [8:0] w_ptr;
  logic [7:0] r_ptr;
  logic       r_en;
  logic       empty_flag;
  logic [7:0] ram_data;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [8:0] level;
`ifdef FIFO_RD_OVF_CHK_EN
  logic       ovf_err;
`endif

  fifo_read_ctrl #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .w_ptr      (w_ptr),
    .r_ptr      (r_ptr),
    .r_en       (r_en),
    .empty_flag (empty_flag),
    .ram_data   (ram_data),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .level      (level)
`ifdef FIFO_RD_OVF_CHK_EN
    ,
    .ovf_err    (ovf_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (r_en) ram_data <= ram[r_ptr];
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [8:0] w;
    logic       rdy;
    logic       e_empty;
    logic       e_ren;
    logic [7:0] e_rptr;
    logic       e_mv;
    logic [7:0] e_md;
    logic [8:0] e_level;
  } vec_t;

  vec_t vecs [18];

  // Scoreboard state: counts of words written, read from RAM and delivered.
  logic [8:0] mrd;
  int         issued, pop_cnt, w_cnt, wrap_hits;
  bit         inflight_m, prev_stall;
  logic [7:0] prev_data;
  logic [7:0] expq [$];

  task automatic model_reset();
    mrd = '0; issued = 0; pop_cnt = 0; w_cnt = 0;
    inflight_m = 0; prev_stall = 0; prev_data = '0;
    expq.delete();
  endtask

  task automatic step(input bit wr, input bit rdy);
    logic [8:0] lv;
    logic [8:0] exp_level;
    logic [7:0] wdata;
    bit exp_empty, exp_ren, exp_mv;
    int outstanding;
    @(negedge clk);
    lv = w_ptr - mrd;
    if (wr && lv < 9'd256) begin
      wdata = 8'($urandom);
      ram[w_ptr[7:0]] = wdata;
      expq.push_back(wdata);
      w_ptr = w_ptr + 9'd1;
      w_cnt++;
    end
    m_ready = rdy;
    #1;
    exp_level   = w_ptr - mrd;
    exp_empty   = (exp_level == 9'd0);
    outstanding = issued - pop_cnt;
    exp_ren     = !exp_empty && (outstanding < 2);
    exp_mv      = (outstanding - (inflight_m ? 1 : 0)) > 0;
    if (mrd == 9'h0FF && w_ptr == 9'h100) wrap_hits++;
    chk("rnd_empty", 32'(empty_flag), 32'(exp_empty));
    chk("rnd_level", 32'(level), 32'(exp_level));
    chk("rnd_r_en", 32'(r_en), 32'(exp_ren));
    chk("rnd_m_valid", 32'(m_valid), 32'(exp_mv));
    if (exp_ren) chk("rnd_r_ptr", 32'(r_ptr), 32'(mrd[7:0]));
    if (exp_mv && expq.size() > 0) chk("rnd_m_data", 32'(m_data), 32'(expq[0]));
    if (prev_stall) chk("rnd_hold", 32'(m_data), 32'(prev_data));
    prev_stall = exp_mv && !rdy;
    prev_data  = m_data;
    if (exp_mv && rdy && expq.size() > 0) begin
      void'(expq.pop_front());
      pop_cnt++;
    end
    inflight_m = exp_ren;
    if (exp_ren) begin
      mrd = mrd + 9'd1;
      issued++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    ram[0] = 8'hA5;
    for (int i = 1; i < 256; i++) ram[i] = 8'(8'h30 + i);

    //          w      rdy   emp   ren   rptr   mv    md      level
    vecs[0]  = '{9'd0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'h00, 9'd0};
    vecs[1]  = '{9'd1, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 8'h00, 9'd1};
    vecs[2]  = '{9'd1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'h00, 9'd0};
    vecs[3]  = '{9'd1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'hA5, 9'd0};
    vecs[4]  = '{9'd1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'h00, 9'd0};
    vecs[5]  = '{9'd6, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 8'h00, 9'd5};
    vecs[6]  = '{9'd6, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 8'h00, 9'd4};
    vecs[7]  = '{9'd6, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'h31, 9'd3};
    vecs[8]  = '{9'd6, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'h31, 9'd3};
    vecs[9]  = '{9'd6, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'h31, 9'd3};
    vecs[10] = '{9'd6, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 8'h31, 9'd3};
    vecs[11] = '{9'd6, 1'b1, 1'b0, 1'b1, 8'd3, 1'b1, 8'h32, 9'd3};
    vecs[12] = '{9'd6, 1'b1, 1'b0, 1'b1, 8'd4, 1'b0, 8'h00, 9'd2};
    vecs[13] = '{9'd6, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 8'h33, 9'd1};
    vecs[14] = '{9'd6, 1'b1, 1'b0, 1'b1, 8'd5, 1'b1, 8'h34, 9'd1};
    vecs[15] = '{9'd6, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'h00, 9'd0};
    vecs[16] = '{9'd6, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'h35, 9'd0};
    vecs[17] = '{9'd6, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'h00, 9'd0};

    rst_n = 1'b0; w_ptr = '0; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_m_data", 32'(m_data), 32'h0);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      w_ptr = vecs[i].w; m_ready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_empty", i), 32'(empty_flag), 32'(vecs[i].e_empty));
      chk($sformatf("vec%0d_r_en", i), 32'(r_en), 32'(vecs[i].e_ren));
      chk($sformatf("vec%0d_m_valid", i), 32'(m_valid), 32'(vecs[i].e_mv));
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].e_level));
      if (vecs[i].e_ren) chk($sformatf("vec%0d_r_ptr", i), 32'(r_ptr), 32'(vecs[i].e_rptr));
      if (vecs[i].e_mv) chk($sformatf("vec%0d_m_data", i), 32'(m_data), 32'(vecs[i].e_md));
    end

    // Reset with two words buffered.
    @(negedge clk); w_ptr = 9'd8; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("pre_rst_valid", 32'(m_valid), 32'h1);
    chk("pre_rst_data", 32'(m_data), 32'h36);
    rst_n = 1'b0; w_ptr = '0;
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("post_rst_valid", 32'(m_valid), 32'h0);
    chk("post_rst_empty", 32'(empty_flag), 32'h1);
    chk("post_rst_level", 32'(level), 32'h0);

    // Reset while a RAM read is issued: the returning word must be dropped.
    @(negedge clk); w_ptr = 9'd3; rst_n = 1'b0;
    #1;
    chk("ren_at_rst", 32'(r_en), 32'h1);
    @(negedge clk); w_ptr = '0; rst_n = 1'b1;
    #1;
    chk("late_word_v0", 32'(m_valid), 32'h0);
    @(negedge clk); #1;
    chk("late_word_v1", 32'(m_valid), 32'h0);
    chk("late_word_empty", 32'(empty_flag), 32'h1);

    // Lockstep stream of 300 words across the pointer wrap.
    @(negedge clk); rst_n = 1'b0; w_ptr = '0;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    wrap_hits = 0;
    cyc = 0;
    while (pop_cnt < 300 && cyc < 3000) begin
      step((w_cnt < 300) && (w_ptr == mrd), 1'b1);
      cyc++;
    end
    chk("t4_delivered", 32'(pop_cnt), 32'd300);
    chk("t4_wrap_visited", 32'(wrap_hits > 0), 32'h1);
    @(negedge clk); #1;
    chk("t4_final_r_ptr", 32'(r_ptr), 32'd44);
    chk("t4_final_empty", 32'(empty_flag), 32'h1);

    // 1000 more words with random writer activity and random backpressure.
    cyc = 0;
    while (pop_cnt < 1300 && cyc < 20000) begin
      step((w_cnt < 1300) && ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 60));
      cyc++;
    end
    chk("t5_delivered", 32'(pop_cnt), 32'd1300);
    chk("t5_queue_empty", 32'(expq.size()), 32'd0);
    @(negedge clk); #1;
    chk("t5_final_r_ptr", 32'(r_ptr), 32'd20);

`ifdef FIFO_RD_OVF_CHK_EN
    @(negedge clk); rst_n = 1'b0; w_ptr = '0;
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("ovf_rst", 32'(ovf_err), 32'h0);
    @(negedge clk); w_ptr = 9'h101;
    #1;
    chk("ovf_before_edge", 32'(ovf_err), 32'h0);
    @(negedge clk); #1;
    chk("ovf_set", 32'(ovf_err), 32'h1);
    w_ptr = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("ovf_held", 32'(ovf_err), 32'h1);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("ovf_cleared", 32'(ovf_err), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
